// File: rtl/input_conditioner_pkg.sv
// Shared lab constants for the input conditioning stage.
// Imported by the conditioner top and its per-channel debouncer.
package input_conditioner_pkg;

  localparam int DEBOUNCE_CYCLES_SIM = 4;

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One input channel: two-flop synchronizer, debounce counter,
// and registered level / rise / fall / toggle outputs.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic toggle
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             rise_q;
  logic             rise_d;
  logic             fall_q;
  logic             fall_d;
  logic             toggle_q;
  logic             toggle_d;

  always_comb begin
    cnt_d    = '0;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    toggle_d = toggle_q;
    if (sync2_q != level_q) begin
      // Terminal count: the differing value has held long enough.
      if (cnt_q == TERM) begin
        level_d  = sync2_q;
        rise_d   = sync2_q;
        fall_d   = ~sync2_q;
        toggle_d = toggle_q ^ sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
    end
  end

  assign level  = level_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign toggle = toggle_q;

endmodule

// File: rtl/input_conditioner.sv
// Conditions N raw asynchronous inputs into clean, clk-synchronous
// levels, edge pulses and press-toggled levels.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int N               = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] raw_in,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] toggle
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_in[i]),
      .level (level[i]),
      .rise  (rise[i]),
      .fall  (fall[i]),
      .toggle(toggle[i])
    );
  end

endmodule
